// File: rtl/wb_dma_master.sv
// wb_dma_master
// -----------------------------------------------------------------------------
// Wishbone initiator that copies a block of bytes from a source address to a
// destination address. Each byte is moved as one read followed by one write.
// Typical use is draining the tube data register (0x01xxxxxx) into SRAM, or
// filling it from SRAM. The initiator shares the coprocessor fabric with the
// CPU, and bus ownership comes from an external arbiter.
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   start             one-cycle pulse; accepted only when idle
//   src_adr, dst_adr  byte addresses of the first source and destination byte
//   len               number of bytes to move (0 = no bus activity)
//   src_inc, dst_inc  1 = address +1 per byte, 0 = fixed (FIFO register)
//   busy              transfer in progress
//   done              one-cycle pulse at the end (normal or abort)
//   err               sticky abort flag, cleared by the next accepted start
//   count             bytes completely written so far
//   bus_req, bus_gnt  arbiter request/grant
//   o_wb_* / i_wb_*   Wishbone initiator signals
//
// Handshakes
//   bus_req/bus_gnt: bus_req rises on an accepted start with len != 0 and stays
//   high until the transfer finishes. The first strobe follows the first cycle
//   in which bus_gnt is seen high. The arbiter must hold bus_gnt while bus_req
//   is high.
//   stb/ack: a strobe is offered with cyc=stb=1. Address, sel and we hold
//   steady until a cycle with i_wb_ack or i_wb_err high completes it. If
//   i_wb_err and i_wb_ack are high together, i_wb_err wins and the transfer
//   aborts. After every completed strobe, one idle cycle follows.
//
// Optional feature
//   WB_DMA_TIMEOUT_EN: when defined, a per-strobe watchdog aborts the
//   transfer like i_wb_err after TIMEOUT strobe cycles without ack or err.
//   When undefined, the block waits forever for ack or err.
// -----------------------------------------------------------------------------
module wb_dma_master #(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      src_adr,
  input  logic [31:0]      dst_adr,
  input  logic [LEN_W-1:0] len,
  input  logic             src_inc,
  input  logic             dst_inc,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] count,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic [31:0]      o_wb_adr,
  output logic [3:0]       o_wb_sel,
  output logic             o_wb_we,
  output logic [31:0]      o_wb_dat,
  input  logic [31:0]      i_wb_dat,
  output logic             o_wb_cyc,
  output logic             o_wb_stb,
  input  logic             i_wb_ack,
  input  logic             i_wb_err
);

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("wb_dma_master: TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RD   = 3'd2,
    S_GAP1 = 3'd3,
    S_WR   = 3'd4,
    S_GAP2 = 3'd5,
    S_FIN  = 3'd6
  } state_t;

  state_t           state;
  logic [31:0]      src_a;
  logic [31:0]      dst_a;
  logic [LEN_W-1:0] len_q;
  logic             src_inc_q;
  logic             dst_inc_q;
  logic [7:0]       byte_q;
  logic [7:0]       rd_byte;
  logic             abort;

`ifdef WB_DMA_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [WD_W-1:0] wd;
`endif

  // One-hot byte select for a byte address.
  function automatic logic [3:0] lane_sel(input logic [1:0] a);
    return 4'b0001 << a;
  endfunction

  always_comb begin
    // During RD, o_wb_adr equals src_a, so the low bits of src_a pick the lane.
    case (src_a[1:0])
      2'd0:    rd_byte = i_wb_dat[7:0];
      2'd1:    rd_byte = i_wb_dat[15:8];
      2'd2:    rd_byte = i_wb_dat[23:16];
      default: rd_byte = i_wb_dat[31:24];
    endcase
    abort = i_wb_err;
`ifdef WB_DMA_TIMEOUT_EN
    // wd counts earlier unacknowledged strobe cycles, so this cycle is the
    // TIMEOUT-th one without a response.
    if (!i_wb_ack && wd == WD_W'(TIMEOUT - 1)) abort = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      src_a     <= '0;
      dst_a     <= '0;
      len_q     <= '0;
      src_inc_q <= 1'b0;
      dst_inc_q <= 1'b0;
      byte_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      count     <= '0;
      bus_req   <= 1'b0;
      o_wb_adr  <= '0;
      o_wb_sel  <= '0;
      o_wb_we   <= 1'b0;
      o_wb_dat  <= '0;
      o_wb_cyc  <= 1'b0;
      o_wb_stb  <= 1'b0;
`ifdef WB_DMA_TIMEOUT_EN
      wd        <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            src_a     <= src_adr;
            dst_a     <= dst_adr;
            len_q     <= len;
            src_inc_q <= src_inc;
            dst_inc_q <= dst_inc;
            err       <= 1'b0;
            count     <= '0;
            busy      <= 1'b1;
            if (len == '0) begin
              state <= S_FIN;
            end else begin
              bus_req <= 1'b1;
              state   <= S_REQ;
            end
          end
        end

        S_REQ: begin
          if (bus_gnt) begin
            o_wb_cyc <= 1'b1;
            o_wb_stb <= 1'b1;
            o_wb_we  <= 1'b0;
            o_wb_adr <= src_a;
            o_wb_sel <= lane_sel(src_a[1:0]);
`ifdef WB_DMA_TIMEOUT_EN
            wd       <= '0;
`endif
            state    <= S_RD;
          end
        end

        S_RD: begin
          if (abort) begin
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            err      <= 1'b1;
            state    <= S_FIN;
          end else if (i_wb_ack) begin
            byte_q   <= rd_byte;
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            state    <= S_GAP1;
          end
`ifdef WB_DMA_TIMEOUT_EN
          else begin
            wd <= wd + 1'b1;
          end
`endif
        end

        S_GAP1: begin
          o_wb_cyc <= 1'b1;
          o_wb_stb <= 1'b1;
          o_wb_we  <= 1'b1;
          o_wb_adr <= dst_a;
          o_wb_sel <= lane_sel(dst_a[1:0]);
          o_wb_dat <= {4{byte_q}};
`ifdef WB_DMA_TIMEOUT_EN
          wd       <= '0;
`endif
          state    <= S_WR;
        end

        S_WR: begin
          if (abort) begin
            // The failing byte is not counted and the addresses do not advance.
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_wb_we  <= 1'b0;
            err      <= 1'b1;
            state    <= S_FIN;
          end else if (i_wb_ack) begin
            count    <= count + 1'b1;
            if (src_inc_q) src_a <= src_a + 32'd1;
            if (dst_inc_q) dst_a <= dst_a + 32'd1;
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_wb_we  <= 1'b0;
            state    <= S_GAP2;
          end
`ifdef WB_DMA_TIMEOUT_EN
          else begin
            wd <= wd + 1'b1;
          end
`endif
        end

        S_GAP2: begin
          // count already includes the byte just written.
          if (count == len_q) begin
            state <= S_FIN;
          end else begin
            o_wb_cyc <= 1'b1;
            o_wb_stb <= 1'b1;
            o_wb_we  <= 1'b0;
            o_wb_adr <= src_a;
            o_wb_sel <= lane_sel(src_a[1:0]);
`ifdef WB_DMA_TIMEOUT_EN
            wd       <= '0;
`endif
            state    <= S_RD;
          end
        end

        S_FIN: begin
          // done, !busy and !bus_req all become visible in the same cycle.
          done    <= 1'b1;
          busy    <= 1'b0;
          bus_req <= 1'b0;
          state   <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
